// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg : flit-type encodings, arbiter state type and sizing helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int c_type_w = 2;

  localparam logic [c_type_w-1:0] c_flit_head     = 2'b10;
  localparam logic [c_type_w-1:0] c_flit_body     = 2'b00;
  localparam logic [c_type_w-1:0] c_flit_tail     = 2'b01;
  localparam logic [c_type_w-1:0] c_flit_headtail = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Bits needed to index 'value' distinct items (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A flit that ends a packet releases the output lock.
  function automatic logic is_last(input logic [c_type_w-1:0] ftype);
    return (ftype == c_flit_tail) || (ftype == c_flit_headtail);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from ptr+1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  always_comb begin : p_search
    logic [PTR_W-1:0] idx;
    o_grant = '0;
    w_found = 1'b0;
    idx     = '0;
    // Offset N wraps back to ptr itself, so the last winner is tried last.
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_arbiter.sv
// ----------------------------------------------------------------------------
// output_arbiter : credit-based wormhole output arbiter with packet lock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module output_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN      = 5,
  parameter int FLIT_SIZE = 8,
  parameter int CREDITS   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_IN-1:0]                    req_i,
  input  logic [N_IN*FLIT_SIZE-1:0]          flit_i,
  input  logic                               credit_i,
  output logic [N_IN-1:0]                    read_o,
  output logic [FLIT_SIZE-1:0]               flit_o,
  output logic                               valid_o,
  output logic [N_IN-1:0]                    grant_o,
  output logic [clogb2(CREDITS+1)-1:0]       credit_cnt_o
);

  localparam int c_ptr_w = (N_IN > 1) ? clogb2(N_IN) : 1;
  localparam int c_cnt_w = clogb2(CREDITS + 1);

  localparam logic [c_cnt_w-1:0] c_cred_max = c_cnt_w'(CREDITS);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_rst  = c_ptr_w'(N_IN - 1);

  arb_state_t             r_state;
  logic [c_ptr_w-1:0]     r_ptr;
  logic [c_ptr_w-1:0]     r_gidx;
  logic [N_IN-1:0]        r_grant;
  logic [FLIT_SIZE-1:0]   r_flit;
  logic                   r_valid;
  logic [c_cnt_w-1:0]     r_credit;

  logic [N_IN-1:0]        w_rr_grant;
  logic [c_ptr_w-1:0]     w_rr_idx;
  logic                   w_read_en;
  logic [FLIT_SIZE-1:0]   w_flit_sel;
  logic                   w_last;

  rr_arbiter #(
    .N     (N_IN),
    .PTR_W (c_ptr_w)
  ) u_rr_arbiter (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant)
  );

  always_comb begin
    w_rr_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_rr_grant[i]) begin
        w_rr_idx = c_ptr_w'(i);
      end
    end
  end

  always_comb begin
    w_flit_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_gidx == c_ptr_w'(i)) begin
        w_flit_sel = flit_i[i*FLIT_SIZE +: FLIT_SIZE];
      end
    end
  end

  assign w_last = is_last(w_flit_sel[FLIT_SIZE-1 -: c_type_w]);

  // Pop is suppressed while reset is held so no buffer loses a flit.
  assign w_read_en = rst && (r_state == LOCKED) && req_i[r_gidx] && (r_credit != '0);

  always_comb begin
    read_o         = '0;
    read_o[r_gidx] = w_read_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= c_ptr_rst;
      r_gidx   <= '0;
      r_grant  <= '0;
      r_flit   <= '0;
      r_valid  <= 1'b0;
      r_credit <= c_cred_max;
    end else begin
      r_valid <= w_read_en;
      if (w_read_en) begin
        r_flit <= w_flit_sel;
      end

      // Pop and returned credit in the same cycle cancel out.
      if (w_read_en && !credit_i) begin
        r_credit <= r_credit - c_cnt_one;
      end else if (credit_i && !w_read_en && (r_credit != c_cred_max)) begin
        r_credit <= r_credit + c_cnt_one;
      end

      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_grant <= w_rr_grant;
            r_gidx  <= w_rr_idx;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_read_en && w_last) begin
            r_state <= IDLE;
            r_ptr   <= r_gidx;
            r_grant <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_o      = r_grant;
  assign flit_o       = r_flit;
  assign valid_o      = r_valid;
  assign credit_cnt_o = r_credit;

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// ----------------------------------------------------------------------------
// tb_output_arbiter : scoreboard bench for output_arbiter with input-buffer model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_output_arbiter;

  localparam int K_GRANT  = 0;
  localparam int K_READ   = 1;
  localparam int K_VALID  = 2;
  localparam int K_FLIT   = 3;
  localparam int K_CRED   = 4;
  localparam int K_SBLEFT = 5;

  typedef struct {
    int          kind;
    logic [7:0]  exp;
    string       name;
  } probe_t;

  logic        clk;
  logic        rst;
  logic [4:0]  req_i;
  logic [39:0] flit_i;
  logic        credit_i;
  logic [4:0]  read_o;
  logic [7:0]  flit_o;
  logic        valid_o;
  logic [4:0]  grant_o;
  logic [3:0]  credit_cnt_o;

  logic [7:0]  inq [5][$];
  logic [4:0]  mask;
  logic [7:0]  exp_q [$];
  probe_t      pq [$];
  logic [4:0]  rd_s;

  int n_checks;
  int n_err;

  output_arbiter #(
    .N_IN      (5),
    .FLIT_SIZE (8),
    .CREDITS   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .flit_i       (flit_i),
    .credit_i     (credit_i),
    .read_o       (read_o),
    .flit_o       (flit_o),
    .valid_o      (valid_o),
    .grant_o      (grant_o),
    .credit_cnt_o (credit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input-buffer model: pop at +1 after the edge, present new heads at +3,
  // sample read_o at +8 just before the next edge.
  initial begin
    req_i  = '0;
    flit_i = '0;
    rd_s   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (rd_s[i] && (inq[i].size() > 0)) void'(inq[i].pop_front());
      end
      #2;
      for (int i = 0; i < 5; i++) begin
        req_i[i]          = (inq[i].size() > 0) && mask[i];
        flit_i[i*8 +: 8]  = (inq[i].size() > 0) ? inq[i][0] : 8'h00;
      end
      #5;
      rd_s = read_o;
    end
  end

  // Monitor: resolves probes for the current cycle, then scoreboards flits.
  always @(negedge clk) begin
    probe_t     p;
    logic [7:0] act;
    logic [7:0] e;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.kind)
        K_GRANT:  act = 8'(grant_o);
        K_READ:   act = 8'(read_o);
        K_VALID:  act = 8'(valid_o);
        K_FLIT:   act = flit_o;
        K_CRED:   act = 8'(credit_cnt_o);
        K_SBLEFT: act = 8'(exp_q.size());
        default:  act = 8'hxx;
      endcase
      n_checks = n_checks + 1;
      if (act !== p.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %0h expected %0h at %0t", p.name, act, p.exp, $time);
      end
    end
    if (valid_o === 1'b1) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL sb_unexpected: got flit %0h expected none at %0t", flit_o, $time);
      end else begin
        e = exp_q.pop_front();
        if (flit_o !== e) begin
          n_err = n_err + 1;
          $display("FAIL sb_flit: got %0h expected %0h at %0t", flit_o, e, $time);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic probe(input int k, input logic [7:0] e, input string n);
    probe_t p;
    p.kind = k;
    p.exp  = e;
    p.name = n;
    pq.push_back(p);
  endtask

  task automatic push_pkt(input int port, input logic [7:0] f);
    inq[port].push_back(f);
    exp_q.push_back(f);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    credit_i = 1'b0;
    mask     = '1;
    for (int i = 0; i < 5; i++) inq[i].delete();
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    credit_i = 1'b0;
    mask     = '1;

    // Reset state
    tick(2);
    probe(K_GRANT, 8'h00, "rst_grant");
    probe(K_VALID, 8'h00, "rst_valid");
    probe(K_FLIT,  8'h00, "rst_flit");
    probe(K_CRED,  8'h08, "rst_credit");
    probe(K_READ,  8'h00, "rst_read");
    rst = 1'b1;

    // Single HEADTAIL request on input 2
    tick();
    push_pkt(2, 8'hC5);
    tick();
    probe(K_GRANT, 8'h04, "t1_grant");
    probe(K_READ,  8'h04, "t1_read");
    tick();
    probe(K_VALID, 8'h01, "t1_valid");
    probe(K_FLIT,  8'hC5, "t1_flit");
    probe(K_CRED,  8'h07, "t1_credit");
    tick();
    probe(K_GRANT, 8'h00, "t1_grant_clr");
    probe(K_VALID, 8'h00, "t1_valid_clr");

    // Round-robin between inputs 0 and 3
    do_reset();
    tick();
    push_pkt(0, 8'hC1); push_pkt(3, 8'hF1);
    push_pkt(0, 8'hC2); push_pkt(3, 8'hF2);
    push_pkt(0, 8'hC3); push_pkt(3, 8'hF3);
    tick();    probe(K_GRANT, 8'h01, "rr_grant0");
    tick(2);   probe(K_GRANT, 8'h08, "rr_grant1");
    tick(2);   probe(K_GRANT, 8'h01, "rr_grant2");
    tick(2);   probe(K_GRANT, 8'h08, "rr_grant3");
    tick(7);
    probe(K_CRED,   8'h02, "rr_credit");
    probe(K_SBLEFT, 8'h00, "rr_sb_empty");

    // Packet lock: input 1 HEAD/BODY/TAIL with a request gap, input 4 waiting
    do_reset();
    tick();
    push_pkt(1, 8'h81); push_pkt(1, 8'h02); push_pkt(1, 8'h43);
    push_pkt(4, 8'hE4);
    tick();    probe(K_GRANT, 8'h02, "lock_grant");
    tick();    mask[1] = 1'b0;
    tick();
    probe(K_GRANT, 8'h02, "lock_gap_grant");
    probe(K_VALID, 8'h00, "lock_gap_valid");
    mask[1] = 1'b1;
    tick();    probe(K_GRANT, 8'h02, "lock_tail_grant");
    tick();    probe(K_GRANT, 8'h00, "lock_idle");
    tick();    probe(K_GRANT, 8'h10, "lock_next_grant");
    tick(3);   probe(K_SBLEFT, 8'h00, "lock_sb_empty");

    // Credit exhaustion with a 10-flit packet
    do_reset();
    tick();
    push_pkt(2, 8'h80);
    for (int i = 1; i <= 8; i++) push_pkt(2, 8'(i));
    push_pkt(2, 8'h49);
    tick(11);
    probe(K_CRED,   8'h00, "cx_credit_zero");
    probe(K_VALID,  8'h00, "cx_stalled");
    probe(K_GRANT,  8'h04, "cx_still_locked");
    probe(K_SBLEFT, 8'h02, "cx_eight_sent");
    credit_i = 1'b1;
    tick();    credit_i = 1'b0;
    tick();    credit_i = 1'b1;
    tick();    credit_i = 1'b0;
    tick(3);
    probe(K_SBLEFT, 8'h00, "cx_all_sent");
    probe(K_GRANT,  8'h00, "cx_released");
    probe(K_CRED,   8'h00, "cx_credit_end");

    // Credit saturation and simultaneous pop/credit
    do_reset();
    tick();    credit_i = 1'b1;
    tick();    credit_i = 1'b0;
    probe(K_CRED, 8'h08, "sat_credit");
    push_pkt(0, 8'h80);
    for (int i = 1; i <= 5; i++) push_pkt(0, 8'(i));
    push_pkt(0, 8'h46);
    tick(6);
    probe(K_CRED, 8'h03, "sim_before");
    probe(K_READ, 8'h01, "sim_pop");
    credit_i = 1'b1;
    tick();    credit_i = 1'b0;
    probe(K_CRED, 8'h03, "sim_unchanged");
    tick();    probe(K_CRED, 8'h02, "sim_after");
    tick(3);   probe(K_SBLEFT, 8'h00, "sim_sb_empty");

    // Reset mid-packet after two of four flits
    do_reset();
    tick();
    push_pkt(3, 8'h8C); push_pkt(3, 8'h0D);
    inq[3].push_back(8'h0E); inq[3].push_back(8'h4F);
    tick(3);
    rst = 1'b0;
    inq[3].delete();
    probe(K_READ, 8'h00, "mid_rst_read");
    tick();
    probe(K_GRANT, 8'h00, "mid_rst_grant");
    probe(K_VALID, 8'h00, "mid_rst_valid");
    probe(K_CRED,  8'h08, "mid_rst_credit");
    probe(K_FLIT,  8'h00, "mid_rst_flit");
    rst = 1'b1;
    tick();
    push_pkt(0, 8'hC0); push_pkt(3, 8'hF3);
    tick();    probe(K_GRANT, 8'h01, "mid_rearb0");
    tick(2);   probe(K_GRANT, 8'h08, "mid_rearb3");
    tick(3);   probe(K_SBLEFT, 8'h00, "mid_sb_empty");

    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
